// File: rtl/sap1_controller.sv
// sap1_controller: SAP-1 instruction sequencer. A six-stage T-state ring
// (T1..T6) plus a terminal HALT state, with a combinational decode of the
// current state and opcode into the 12-bit datapath control word.
//
// Ports:
//   clk      - rising-edge clock
//   rst_n    - asynchronous active-low reset (state -> T1, ctrl forced to 0)
//   run      - 1 = advance one T-state per clock, 0 = hold and force ctrl to 0
//   ir_op    - opcode nibble from the instruction register
//   ctrl     - control word {Cp,Ep,Lm,CE,Li,Ei,La,Ea,Su,Eu,Lb,Lo}
//   t_state  - one-hot T-state (bit0 = T1 .. bit5 = T6), zero in HALT
//   halted   - 1 while in HALT
module sap1_controller (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run,
    input  logic [3:0]  ir_op,
    output logic [11:0] ctrl,
    output logic [5:0]  t_state,
    output logic        halted
);

    localparam int unsigned CTRL_W = 12;

    // One-hot state encoding; bits [5:0] double as the t_state output.
    localparam logic [6:0] ST_T1   = 7'b000_0001;
    localparam logic [6:0] ST_T2   = 7'b000_0010;
    localparam logic [6:0] ST_T3   = 7'b000_0100;
    localparam logic [6:0] ST_T4   = 7'b000_1000;
    localparam logic [6:0] ST_T5   = 7'b001_0000;
    localparam logic [6:0] ST_T6   = 7'b010_0000;
    localparam logic [6:0] ST_HALT = 7'b100_0000;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    localparam logic [CTRL_W-1:0] CW_NONE    = 12'h000;
    localparam logic [CTRL_W-1:0] CW_EP_LM   = 12'h600;
    localparam logic [CTRL_W-1:0] CW_CP      = 12'h800;
    localparam logic [CTRL_W-1:0] CW_CE_LI   = 12'h180;
    localparam logic [CTRL_W-1:0] CW_EI_LM   = 12'h240;
    localparam logic [CTRL_W-1:0] CW_CE_LA   = 12'h120;
    localparam logic [CTRL_W-1:0] CW_CE_LB   = 12'h102;
    localparam logic [CTRL_W-1:0] CW_LA_EU   = 12'h024;
    localparam logic [CTRL_W-1:0] CW_LA_SUEU = 12'h02C;
    localparam logic [CTRL_W-1:0] CW_EA_LO   = 12'h011;

    logic [6:0]        state_q;
    logic [6:0]        state_d;
    logic [CTRL_W-1:0] word_c;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_T1;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: ring advances only while run is high; HLT diverts T4 to HALT.
    always_comb begin
        state_d = state_q;
        if (run) begin
            case (state_q)
                ST_T1:   state_d = ST_T2;
                ST_T2:   state_d = ST_T3;
                ST_T3:   state_d = ST_T4;
                ST_T4:   state_d = (ir_op == OP_HLT) ? ST_HALT : ST_T5;
                ST_T5:   state_d = ST_T6;
                ST_T6:   state_d = ST_T1;
                ST_HALT: state_d = ST_HALT;
                default: state_d = ST_T1;
            endcase
        end
    end

    // Control word decode; ir_op is only consulted in the execute states.
    always_comb begin
        word_c = CW_NONE;
        case (state_q)
            ST_T1: word_c = CW_EP_LM;
            ST_T2: word_c = CW_CP;
            ST_T3: word_c = CW_CE_LI;
            ST_T4: begin
                case (ir_op)
                    OP_LDA, OP_ADD, OP_SUB: word_c = CW_EI_LM;
                    OP_OUT:                 word_c = CW_EA_LO;
                    default:                word_c = CW_NONE;
                endcase
            end
            ST_T5: begin
                case (ir_op)
                    OP_LDA:         word_c = CW_CE_LA;
                    OP_ADD, OP_SUB: word_c = CW_CE_LB;
                    default:        word_c = CW_NONE;
                endcase
            end
            ST_T6: begin
                case (ir_op)
                    OP_ADD:  word_c = CW_LA_EU;
                    OP_SUB:  word_c = CW_LA_SUEU;
                    default: word_c = CW_NONE;
                endcase
            end
            default: word_c = CW_NONE;
        endcase
    end

    // Pause and reset both gate the word off without latency.
    assign ctrl    = (rst_n && run) ? word_c : CW_NONE;
    assign t_state = state_q[5:0];
    assign halted  = state_q[6];

endmodule

// File: tb/tb_sap1_controller.sv
// tb_sap1_controller: scoreboard bench for sap1_controller. Each scenario
// task pushes the expected {ctrl, t_state, halted} as it drives a cycle and
// pops it when the outputs are sampled on the falling edge.
module tb_sap1_controller;

    typedef struct packed {
        logic [11:0] c;
        logic [5:0]  t;
        logic        h;
    } exp_t;

    typedef struct packed {
        logic        r;
        logic [3:0]  op;
        exp_t        e;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run;
    logic [3:0]  ir_op;
    logic [11:0] ctrl;
    logic [5:0]  t_state;
    logic        halted;

    int vectors     = 0;
    int miscompares = 0;
    exp_t sb[$];

    sap1_controller dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (run),
        .ir_op   (ir_op),
        .ctrl    (ctrl),
        .t_state (t_state),
        .halted  (halted)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic r, input logic [3:0] op,
                                input logic [11:0] c, input logic [5:0] t, input logic h);
        vec_t v;
        v.r   = r;
        v.op  = op;
        v.e.c = c;
        v.e.t = t;
        v.e.h = h;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        run   = v.r;
        ir_op = v.op;
        sb.push_back(v.e);
    endtask

    // Reset with run high, checked asynchronously and across an edge; leaves DUT in T1.
    task automatic test_reset_pulse(input string tag);
        exp_t e, o;
        run   = 1'b1;
        ir_op = 4'hF;
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            sb.push_back({12'h000, 6'b000001, 1'b0});
            if (k == 0) #1; else begin @(posedge clk); #1; end
            e = sb.pop_front();
            o = {ctrl, t_state, halted};
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL %s_in_reset[%0d]: got ctrl=%h t=%b halted=%b, expected ctrl=%h t=%b halted=%b",
                         tag, k, o.c, o.t, o.h, e.c, e.t, e.h);
            end
        end
        run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        vec_t v[$];
        exp_t e, o;
        test_reset_pulse("reset");
        v = '{mk(1'b0, 4'h0, 12'h000, 6'b000001, 1'b0),
              mk(1'b0, 4'h0, 12'h000, 6'b000001, 1'b0),
              mk(1'b1, 4'h0, 12'h600, 6'b000001, 1'b0),
              mk(1'b1, 4'h0, 12'h800, 6'b000010, 1'b0)};
        foreach (v[i]) begin
            drive(v[i]);
            @(negedge clk);
            e = sb.pop_front();
            o = {ctrl, t_state, halted};
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL after_reset[%0d]: got ctrl=%h t=%b halted=%b, expected ctrl=%h t=%b halted=%b",
                         i, o.c, o.t, o.h, e.c, e.t, e.h);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_lda();
        vec_t v[$];
        exp_t e, o;
        test_reset_pulse("lda");
        v = '{mk(1'b1, 4'h0, 12'h600, 6'b000001, 1'b0),
              mk(1'b1, 4'h0, 12'h800, 6'b000010, 1'b0),
              mk(1'b1, 4'h0, 12'h180, 6'b000100, 1'b0),
              mk(1'b1, 4'h0, 12'h240, 6'b001000, 1'b0),
              mk(1'b1, 4'h0, 12'h120, 6'b010000, 1'b0),
              mk(1'b1, 4'h0, 12'h000, 6'b100000, 1'b0),
              mk(1'b1, 4'h0, 12'h600, 6'b000001, 1'b0)};
        foreach (v[i]) begin
            drive(v[i]);
            @(negedge clk);
            e = sb.pop_front();
            o = {ctrl, t_state, halted};
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL lda[%0d]: got ctrl=%h t=%b halted=%b, expected ctrl=%h t=%b halted=%b",
                         i, o.c, o.t, o.h, e.c, e.t, e.h);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_add_sub();
        vec_t v[$];
        exp_t e, o;
        logic [3:0]  op;
        logic [11:0] t6;
        for (int n = 0; n < 2; n++) begin
            op = (n == 0) ? 4'b0010 : 4'b0001;
            t6 = (n == 0) ? 12'h02C : 12'h024;
            test_reset_pulse("add_sub");
            v = '{mk(1'b1, op, 12'h600, 6'b000001, 1'b0),
                  mk(1'b1, op, 12'h800, 6'b000010, 1'b0),
                  mk(1'b1, op, 12'h180, 6'b000100, 1'b0),
                  mk(1'b1, op, 12'h240, 6'b001000, 1'b0),
                  mk(1'b1, op, 12'h102, 6'b010000, 1'b0),
                  mk(1'b1, op, t6,      6'b100000, 1'b0),
                  mk(1'b1, op, 12'h600, 6'b000001, 1'b0)};
            foreach (v[i]) begin
                drive(v[i]);
                @(negedge clk);
                e = sb.pop_front();
                o = {ctrl, t_state, halted};
                vectors++;
                if (o !== e) begin
                    miscompares++;
                    $display("FAIL add_sub op=%b [%0d]: got ctrl=%h t=%b halted=%b, expected ctrl=%h t=%b halted=%b",
                             op, i, o.c, o.t, o.h, e.c, e.t, e.h);
                end
                @(posedge clk);
                #1;
            end
        end
    endtask

    // OUT, then a NOP opcode with ir_op scrambled during fetch.
    task automatic test_out_nop();
        vec_t v[$];
        exp_t e, o;
        test_reset_pulse("out");
        v = '{mk(1'b1, 4'hE, 12'h600, 6'b000001, 1'b0),
              mk(1'b1, 4'hE, 12'h800, 6'b000010, 1'b0),
              mk(1'b1, 4'hE, 12'h180, 6'b000100, 1'b0),
              mk(1'b1, 4'hE, 12'h011, 6'b001000, 1'b0),
              mk(1'b1, 4'hE, 12'h000, 6'b010000, 1'b0),
              mk(1'b1, 4'hE, 12'h000, 6'b100000, 1'b0),
              mk(1'b1, 4'hF, 12'h600, 6'b000001, 1'b0),
              mk(1'b1, 4'h2, 12'h800, 6'b000010, 1'b0),
              mk(1'b1, 4'(4'h3 + $urandom_range(0, 10)), 12'h180, 6'b000100, 1'b0),
              mk(1'b1, 4'h5, 12'h000, 6'b001000, 1'b0),
              mk(1'b1, 4'h5, 12'h000, 6'b010000, 1'b0),
              mk(1'b1, 4'h5, 12'h000, 6'b100000, 1'b0),
              mk(1'b1, 4'h5, 12'h600, 6'b000001, 1'b0)};
        foreach (v[i]) begin
            drive(v[i]);
            @(negedge clk);
            e = sb.pop_front();
            o = {ctrl, t_state, halted};
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL out_nop[%0d]: got ctrl=%h t=%b halted=%b, expected ctrl=%h t=%b halted=%b",
                         i, o.c, o.t, o.h, e.c, e.t, e.h);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_hlt();
        vec_t v[$];
        exp_t e, o;
        test_reset_pulse("hlt");
        v = '{mk(1'b1, 4'hF, 12'h600, 6'b000001, 1'b0),
              mk(1'b1, 4'hF, 12'h800, 6'b000010, 1'b0),
              mk(1'b1, 4'hF, 12'h180, 6'b000100, 1'b0),
              mk(1'b1, 4'hF, 12'h000, 6'b001000, 1'b0)};
        for (int k = 0; k < 20; k++) begin
            v.push_back(mk(1'(k % 2 == 0), 4'(k), 12'h000, 6'b000000, 1'b1));
        end
        foreach (v[i]) begin
            drive(v[i]);
            @(negedge clk);
            e = sb.pop_front();
            o = {ctrl, t_state, halted};
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL hlt[%0d]: got ctrl=%h t=%b halted=%b, expected ctrl=%h t=%b halted=%b",
                         i, o.c, o.t, o.h, e.c, e.t, e.h);
            end
            @(posedge clk);
            #1;
        end
        test_reset_pulse("hlt_exit");
    endtask

    task automatic test_pause();
        vec_t v[$];
        exp_t e, o;
        test_reset_pulse("pause");
        v = '{mk(1'b1, 4'h0, 12'h600, 6'b000001, 1'b0),
              mk(1'b1, 4'h0, 12'h800, 6'b000010, 1'b0),
              mk(1'b0, 4'h0, 12'h000, 6'b000100, 1'b0),
              mk(1'b0, 4'h0, 12'h000, 6'b000100, 1'b0),
              mk(1'b0, 4'h0, 12'h000, 6'b000100, 1'b0),
              mk(1'b1, 4'h0, 12'h180, 6'b000100, 1'b0),
              mk(1'b1, 4'h0, 12'h240, 6'b001000, 1'b0),
              mk(1'b1, 4'h0, 12'h120, 6'b010000, 1'b0)};
        foreach (v[i]) begin
            drive(v[i]);
            @(negedge clk);
            e = sb.pop_front();
            o = {ctrl, t_state, halted};
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL pause[%0d]: got ctrl=%h t=%b halted=%b, expected ctrl=%h t=%b halted=%b",
                         i, o.c, o.t, o.h, e.c, e.t, e.h);
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Reset dropped between edges in T5 of ADD must take effect before the next edge.
    task automatic test_async_reset_mid();
        vec_t v[$];
        exp_t e, o;
        test_reset_pulse("mid");
        v = '{mk(1'b1, 4'h1, 12'h600, 6'b000001, 1'b0),
              mk(1'b1, 4'h1, 12'h800, 6'b000010, 1'b0),
              mk(1'b1, 4'h1, 12'h180, 6'b000100, 1'b0),
              mk(1'b1, 4'h1, 12'h240, 6'b001000, 1'b0),
              mk(1'b1, 4'h1, 12'h102, 6'b010000, 1'b0)};
        foreach (v[i]) begin
            drive(v[i]);
            @(negedge clk);
            e = sb.pop_front();
            o = {ctrl, t_state, halted};
            vectors++;
            if (o !== e) begin
                miscompares++;
                $display("FAIL mid[%0d]: got ctrl=%h t=%b halted=%b, expected ctrl=%h t=%b halted=%b",
                         i, o.c, o.t, o.h, e.c, e.t, e.h);
            end
            if (i < v.size() - 1) begin
                @(posedge clk);
                #1;
            end
        end
        #2;
        rst_n = 1'b0;
        sb.push_back({12'h000, 6'b000001, 1'b0});
        #1;
        e = sb.pop_front();
        o = {ctrl, t_state, halted};
        vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL mid_async: got ctrl=%h t=%b halted=%b, expected ctrl=%h t=%b halted=%b",
                     o.c, o.t, o.h, e.c, e.t, e.h);
        end
        run = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive(mk(1'b1, 4'h1, 12'h600, 6'b000001, 1'b0));
        @(negedge clk);
        e = sb.pop_front();
        o = {ctrl, t_state, halted};
        vectors++;
        if (o !== e) begin
            miscompares++;
            $display("FAIL mid_restart: got ctrl=%h t=%b halted=%b, expected ctrl=%h t=%b halted=%b",
                     o.c, o.t, o.h, e.c, e.t, e.h);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b1;
        run   = 1'b0;
        ir_op = 4'h0;
        #2;
        test_reset();
        test_lda();
        test_add_sub();
        test_out_nop();
        test_hlt();
        test_pause();
        test_async_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
